freq_seq_ctrl: RTL

FREQ_SEQ_CTRL -- requirements
Module: freq_seq_ctrl

---
 rtl/freq_seq_if.sv | 25 ++
 rtl/freq_seq_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/freq_seq_if.sv
// freq_seq_if: control, pattern-table write and divider handshake bundle for freq_seq_ctrl
interface freq_seq_if #(parameter int DUR_W = 4);
  logic             start;
  logic             stop;
  logic [2:0]       seq_len;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [2:0]       wr_code;
  logic [DUR_W-1:0] wr_dur;
  logic             co_i;
  logic             ld_o;
  logic [2:0]       cnt_o;
  logic             tone_o;
  logic             busy;
  logic             done;
  logic [2:0]       step_o;
  modport master (
    output start, stop, seq_len, wr_en, wr_addr, wr_code, wr_dur, co_i,
    input  ld_o, cnt_o, tone_o, busy, done, step_o
  );
  modport slave (
    input  start, stop, seq_len, wr_en, wr_addr, wr_code, wr_dur, co_i,
    output ld_o, cnt_o, tone_o, busy, done, step_o
  );
endinterface

// File: rtl/freq_seq_ctrl.sv
// freq_seq_ctrl: plays a table of divider codes for per-step co_i pulse counts; FREQ_SEQ_LOOP_EN makes playback loop until stop
module freq_seq_ctrl #(parameter int DUR_W = 4) (
  input logic       clk,
  input logic       rst_n,
  freq_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
`ifdef FREQ_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic [1:0]            state_q, state_d;
  logic [2:0]            step_q, step_d, len_q, len_d, next_step;
  logic [DUR_W-1:0]      pcnt_q, pcnt_d;
  logic                  tone_q, tone_d, done_q, done_d;
  logic [7:0][2:0]       code_q, code_d;
  logic [7:0][DUR_W-1:0] dur_q, dur_d;
  logic                  run_co, last, step_end;
  always_comb begin
    run_co = state_q == RUN && bus.co_i && !bus.stop;
    last = step_q == len_q;
    next_step = last ? 3'd0 : step_q + 3'd1;
    // pulse count wraps in DUR_W bits, so dur=0 ends the step after 2^DUR_W pulses
    step_end = pcnt_q + DUR_W'(1) == dur_q[step_q];
    state_d = state_q;
    step_d = step_q;
    len_d = len_q;
    pcnt_d = pcnt_q;
    tone_d = tone_q;
    done_d = 1'b0;
    code_d = code_q;
    dur_d = dur_q;
    if (state_q == IDLE && bus.wr_en) begin
      code_d[bus.wr_addr] = bus.wr_code;
      dur_d[bus.wr_addr] = bus.wr_dur;
    end
    if (state_q == IDLE && bus.start && !bus.stop) begin
      state_d = LOAD;
      len_d = bus.seq_len;
    end
    if (state_q == LOAD) state_d = bus.stop ? IDLE : RUN;
    if (state_q == RUN && bus.stop) begin
      state_d = IDLE;
      step_d = '0;
      pcnt_d = '0;
      tone_d = 1'b0;
    end
    if (run_co) begin
      tone_d = ~tone_q;
      pcnt_d = step_end ? '0 : pcnt_q + DUR_W'(1);
      step_d = step_end ? next_step : step_q;
      if (step_end && last && !LOOP) begin
        state_d = IDLE;
        done_d = 1'b1;
        tone_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q <= '0;
      len_q <= '0;
      pcnt_q <= '0;
      tone_q <= 1'b0;
      done_q <= 1'b0;
      code_q <= '0;
      dur_q <= {8{DUR_W'(1)}};
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      len_q <= len_d;
      pcnt_q <= pcnt_d;
      tone_q <= tone_d;
      done_q <= done_d;
      code_q <= code_d;
      dur_q <= dur_d;
    end
  end
  // a reload replaces the divider's own wrap, and stop suppresses it
  assign bus.ld_o = state_q == LOAD || run_co;
  assign bus.cnt_o = state_q == IDLE ? 3'd0 : (run_co && step_end) ? code_q[next_step] : code_q[step_q];
  assign bus.step_o = step_q;
  assign bus.tone_o = tone_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
endmodule
